// File: rtl/buffer_ptr_ctrl_pkg.sv
// rtl/buffer_ptr_ctrl_pkg.sv - shared types, pointer wrap helper and parameter legality check
package buffer_ptr_ctrl_pkg;

    typedef struct packed {
        logic full;
        logic empty;
        logic afull;
        logic aempty;
    } flags_t;

    localparam flags_t FLAGS_RST = '{full: 1'b0, empty: 1'b1, afull: 1'b0, aempty: 1'b1};

    function automatic int unsigned next_ptr(input int unsigned ptr, input int unsigned depth);
        return (ptr == depth - 1) ? 0 : ptr + 1;
    endfunction

    function automatic bit params_legal(input int bw, input int depth,
                                        input int afull_th, input int aempty_th);
        return (depth >= 2) && (depth <= (1 << bw)) &&
               (afull_th >= 1) && (afull_th <= depth) &&
               (aempty_th >= 0) && (aempty_th <= depth - 1);
    endfunction

endpackage

// File: rtl/buffer_ptr_ctrl_if.sv
// rtl/buffer_ptr_ctrl_if.sv - producer/consumer requests and buffer status bundle
interface buffer_ptr_ctrl_if #(
    parameter int BufferWidth = 2
);
    logic                   Push;
    logic                   Pop;
    logic                   ClrErr;
    logic                   W_En;
    logic                   R_En;
    logic [BufferWidth-1:0] W_Addr;
    logic [BufferWidth-1:0] R_Addr;
    logic                   Round;
    logic                   Full;
    logic                   Empty;
    logic [BufferWidth:0]   Count;
    logic                   AlmostFull;
    logic                   AlmostEmpty;
    logic                   Overflow;
    logic                   Underflow;

    modport slave (
        input  Push, Pop, ClrErr,
        output W_En, R_En, W_Addr, R_Addr, Round, Full, Empty, Count,
               AlmostFull, AlmostEmpty, Overflow, Underflow
    );

    modport master (
        output Push, Pop, ClrErr,
        input  W_En, R_En, W_Addr, R_Addr, Round, Full, Empty, Count,
               AlmostFull, AlmostEmpty, Overflow, Underflow
    );
endinterface

// File: rtl/buffer_ptr_ctrl_ptr_wrap_counter.sv
// rtl/buffer_ptr_ctrl_ptr_wrap_counter.sv - address counter wrapping at Depth-1 with wrap pulse
module ptr_wrap_counter
    import buffer_ptr_ctrl_pkg::*;
#(
    parameter int BufferWidth = 2,
    parameter int Depth       = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_advance,
    output logic [BufferWidth-1:0] o_addr,
    output logic                   o_wrap
);
    logic [BufferWidth-1:0] r_addr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_addr <= '0;
        end else if (i_advance) begin
            r_addr <= BufferWidth'(next_ptr(32'(r_addr), $unsigned(Depth)));
        end
    end

    assign o_addr = r_addr;
    assign o_wrap = i_advance & (r_addr == BufferWidth'(Depth - 1));

endmodule

// File: rtl/buffer_ptr_ctrl.sv
// rtl/buffer_ptr_ctrl.sv - circular buffer pointer, occupancy and status controller
module buffer_ptr_ctrl
    import buffer_ptr_ctrl_pkg::*;
#(
    parameter int BufferWidth = 2,
    parameter int Depth       = 4,
    parameter int AFullTh     = 3,
    parameter int AEmptyTh    = 1
) (
    input  logic               clk,
    input  logic               rst,
    buffer_ptr_ctrl_if.slave   bus
);
    localparam int CW = BufferWidth + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(Depth);
    localparam logic [CW-1:0] AFULL_C = CW'(AFullTh);
    localparam logic [CW-1:0] AEMPTY_C = CW'(AEmptyTh);

    if (!params_legal(BufferWidth, Depth, AFullTh, AEmptyTh)) begin : g_illegal_params
        $error("buffer_ptr_ctrl: illegal Depth/threshold parameters");
    end

    logic            w_push_acc;
    logic            w_pop_acc;
    logic            w_wr_wrap;
    logic            w_rd_wrap;
    logic [CW-1:0]   r_count;
    logic [CW-1:0]   w_count_nxt;
    logic            r_round;
    logic            r_ovf;
    logic            r_unf;
    flags_t          r_flags;
    flags_t          w_flags_nxt;

    // Full and Empty are registered, so acceptance never depends on this cycle's count math
    assign w_pop_acc  = bus.Pop & ~r_flags.empty & ~rst;
    assign w_push_acc = bus.Push & (~r_flags.full | w_pop_acc) & ~rst;

    ptr_wrap_counter #(.BufferWidth(BufferWidth), .Depth(Depth)) u_wr_ptr (
        .clk       (clk),
        .rst       (rst),
        .i_advance (w_push_acc),
        .o_addr    (bus.W_Addr),
        .o_wrap    (w_wr_wrap)
    );

    ptr_wrap_counter #(.BufferWidth(BufferWidth), .Depth(Depth)) u_rd_ptr (
        .clk       (clk),
        .rst       (rst),
        .i_advance (w_pop_acc),
        .o_addr    (bus.R_Addr),
        .o_wrap    (w_rd_wrap)
    );

    always_comb begin
        w_count_nxt = r_count;
        if (w_push_acc && !w_pop_acc) begin
            w_count_nxt = r_count + 1'b1;
        end else if (w_pop_acc && !w_push_acc) begin
            w_count_nxt = r_count - 1'b1;
        end
    end

    always_comb begin
        w_flags_nxt        = FLAGS_RST;
        w_flags_nxt.full   = (w_count_nxt == DEPTH_C);
        w_flags_nxt.empty  = (w_count_nxt == '0);
        w_flags_nxt.afull  = (w_count_nxt >= AFULL_C);
        w_flags_nxt.aempty = (w_count_nxt <= AEMPTY_C);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
            r_round <= 1'b0;
            r_flags <= FLAGS_RST;
            r_ovf   <= 1'b0;
            r_unf   <= 1'b0;
        end else begin
            r_count <= w_count_nxt;
            r_round <= r_round ^ (w_wr_wrap ^ w_rd_wrap);
            r_flags <= w_flags_nxt;
            // a new error event outranks a same-cycle clear
            r_ovf   <= (bus.Push & ~w_push_acc) | (r_ovf & ~bus.ClrErr);
            r_unf   <= (bus.Pop & ~w_pop_acc) | (r_unf & ~bus.ClrErr);
        end
    end

    assign bus.W_En        = w_push_acc;
    assign bus.R_En        = w_pop_acc;
    assign bus.Round       = r_round;
    assign bus.Count       = r_count;
    assign bus.Full        = r_flags.full;
    assign bus.Empty       = r_flags.empty;
    assign bus.AlmostFull  = r_flags.afull;
    assign bus.AlmostEmpty = r_flags.aempty;
    assign bus.Overflow    = r_ovf;
    assign bus.Underflow   = r_unf;

endmodule

// File: tb/tb_buffer_ptr_ctrl.sv
// tb/tb_buffer_ptr_ctrl.sv - randomized bench with a running-total reference model, two parameter sets
module tb_buffer_ptr_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic push = 1'b0;
    logic pop = 1'b0;
    logic clr = 1'b0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    buffer_ptr_ctrl_if #(.BufferWidth(2)) if_a ();
    buffer_ptr_ctrl_if #(.BufferWidth(2)) if_b ();

    assign if_a.Push = push;
    assign if_a.Pop = pop;
    assign if_a.ClrErr = clr;
    assign if_b.Push = push;
    assign if_b.Pop = pop;
    assign if_b.ClrErr = clr;

    buffer_ptr_ctrl dut_a (.clk(clk), .rst(rst), .bus(if_a));

    buffer_ptr_ctrl #(.BufferWidth(2), .Depth(3), .AFullTh(2), .AEmptyTh(0))
        dut_b (.clk(clk), .rst(rst), .bus(if_b));

    logic [15:0] obs [2];
    assign obs[0] = {if_a.W_En, if_a.R_En, if_a.W_Addr, if_a.R_Addr, if_a.Round, if_a.Full,
                     if_a.Empty, if_a.Count, if_a.AlmostFull, if_a.AlmostEmpty,
                     if_a.Overflow, if_a.Underflow};
    assign obs[1] = {if_b.W_En, if_b.R_En, if_b.W_Addr, if_b.R_Addr, if_b.Round, if_b.Full,
                     if_b.Empty, if_b.Count, if_b.AlmostFull, if_b.AlmostEmpty,
                     if_b.Overflow, if_b.Underflow};

    // Model state: lifetime totals of accepted writes/reads; everything else derives from them
    int unsigned wr_tot [2];
    int unsigned rd_tot [2];
    bit          m_ovf  [2];
    bit          m_unf  [2];
    int unsigned m_depth [2] = '{4, 3};
    int unsigned m_afull [2] = '{3, 2};
    int unsigned m_aempty[2] = '{1, 0};

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic model_eval(input int k, output logic [15:0] e, output bit wa, output bit pa);
        int unsigned c;
        int unsigned d;
        d  = m_depth[k];
        c  = wr_tot[k] - rd_tot[k];
        pa = pop && (c != 0) && !rst;
        wa = push && ((c != d) || pa) && !rst;
        e  = {wa, pa, 2'(wr_tot[k] % d), 2'(rd_tot[k] % d),
              1'(((wr_tot[k] / d) - (rd_tot[k] / d)) % 2),
              (c == d), (c == 0), 3'(c), (c >= m_afull[k]), (c <= m_aempty[k]),
              m_ovf[k], m_unf[k]};
    endtask

    initial begin
        logic [15:0] e;
        bit wa, pa;
        forever begin
            @(negedge clk);
            #3;
            for (int k = 0; k < 2; k++) begin
                if (rst) begin
                    wr_tot[k] = 0;
                    rd_tot[k] = 0;
                    m_ovf[k]  = 0;
                    m_unf[k]  = 0;
                end
                model_eval(k, e, wa, pa);
                chk(k == 0 ? "outputs_d4" : "outputs_d3", int'(obs[k]), int'(e));
                if (!rst) begin
                    wr_tot[k] += wa;
                    rd_tot[k] += pa;
                    m_ovf[k] = (push && !wa) || (m_ovf[k] && !clr);
                    m_unf[k] = (pop && !pa) || (m_unf[k] && !clr);
                end
            end
        end
    end

    task automatic drive(input bit p, input bit q, input bit c);
        @(negedge clk);
        push = p;
        pop  = q;
        clr  = c;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cyc(input bit p, input bit q, input bit c);
        drive(p, q, c);
        tick();
    endtask

    task automatic do_reset();
        @(negedge clk);
        push = 0; pop = 0; clr = 0;
        rst = 1;
        @(negedge clk);
        rst = 0;
    endtask

    initial begin
        int wexp[4] = '{1, 2, 3, 0};
        repeat (2) @(negedge clk);
        rst = 0;
        tick();
        chk("rst_waddr", if_a.W_Addr, 0);
        chk("rst_raddr", if_a.R_Addr, 0);
        chk("rst_count", if_a.Count, 0);
        chk("rst_empty", if_a.Empty, 1);
        chk("rst_aempty", if_a.AlmostEmpty, 1);
        chk("rst_other", {if_a.Round, if_a.Full, if_a.AlmostFull, if_a.Overflow, if_a.Underflow}, 0);

        for (int i = 0; i < 4; i++) begin
            cyc(1, 0, 0);
            chk("fill_waddr", if_a.W_Addr, wexp[i]);
            if (i == 2) chk("fill_afull", if_a.AlmostFull, 1);
        end
        chk("fill_round", if_a.Round, 1);
        chk("fill_full", if_a.Full, 1);
        chk("fill_count", if_a.Count, 4);

        drive(1, 0, 0);
        chk("full_push_wen", if_a.W_En, 0);
        tick();
        chk("full_push_ovf", if_a.Overflow, 1);
        chk("full_push_count", if_a.Count, 4);
        chk("full_push_waddr", if_a.W_Addr, 0);

        drive(1, 1, 0);
        chk("full_pp_en", {if_a.W_En, if_a.R_En}, 3);
        tick();
        chk("full_pp_count", if_a.Count, 4);
        chk("full_pp_full", if_a.Full, 1);

        cyc(0, 0, 1);
        chk("clr_ovf", if_a.Overflow, 0);
        repeat (4) cyc(0, 1, 0);
        chk("drain_empty", if_a.Empty, 1);
        cyc(0, 1, 0);
        chk("empty_pop_unf", if_a.Underflow, 1);
        cyc(0, 0, 1);
        chk("clr_unf", if_a.Underflow, 0);
        cyc(0, 1, 1);
        chk("clr_vs_set_unf", if_a.Underflow, 1);
        cyc(1, 1, 0);
        chk("empty_pp_count", if_a.Count, 1);
        chk("empty_pp_raddr", if_a.R_Addr, 1);

        do_reset();
        for (int i = 0; i < 8; i++) begin
            cyc(i < 7, i > 0, 0);
            chk("d3_waddr", if_b.W_Addr, ((i < 7 ? i + 1 : 7) % 3));
            chk("d3_count", if_b.Count, (i < 7) ? 1 : 0);
        end

        do_reset();
        cyc(1, 0, 0);
        cyc(1, 0, 0);
        chk("mid_count_before", if_a.Count, 2);
        @(negedge clk);
        push = 0;
        #1 rst = 1;
        #1;
        chk("async_rst_count", if_a.Count, 0);
        chk("async_rst_waddr", if_a.W_Addr, 0);
        chk("async_rst_empty", if_a.Empty, 1);
        @(negedge clk);
        rst = 0;

        for (int n = 0; n < 800; n++) begin
            @(negedge clk);
            push = ($urandom_range(0, 99) < 55);
            pop  = ($urandom_range(0, 99) < 50);
            clr  = ($urandom_range(0, 99) < 8);
            rst  = ($urandom_range(0, 199) == 0);
        end
        @(negedge clk);
        push = 0; pop = 0; clr = 0; rst = 0;
        repeat (2) @(negedge clk);
        #5;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
